mem_check_ctrl: RTL and testbench

- Parametrised successor control engine for the memory checker.
- Drives an Avalon-MM master port: issues N write and/or read commands over a contiguous address range, pipelines reads up to a configurable outstanding limit, and compares returned data in-order against a generated pattern.
- Reports busy/done, a saturating error count and the first failing address to the CSR block.

---
 rtl/mem_check_pkg.sv | 28 ++
 rtl/mem_check_rd_cmp.sv | 59 +++++
 rtl/mem_check_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mem_check_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_check_pkg.sv
// Shared types and the data-pattern generator for the memory checker.
package mem_check_pkg;

  // Width the pattern helper works in; callers cast to their own data width.
  localparam int PAT_W = 64;

  typedef enum logic [1:0] {
    WO   = 2'b00,
    RO   = 2'b01,
    WR   = 2'b10,
    RSVD = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Pattern word for a given command index: seed XOR zero-extended index.
  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] seed,
                                               input logic [PAT_W-1:0] index);
    return seed ^ index;
  endfunction

endpackage

// File: rtl/mem_check_rd_cmp.sv
// In-order read-data checker: regenerates the expected pattern for every
// returned read, counts mismatches (saturating) and captures the address of
// the first mismatch since the last clear.
module mem_check_rd_cmp
  import mem_check_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              clr,
  input  logic              rdv,
  input  logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] base,
  input  logic [DATA_W-1:0] seed,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic [CNT_W-1:0]  cmp_idx;
  logic              err_seen;
  logic [DATA_W-1:0] exp_data;
  logic              mismatch;

  // Expected word for the next returned read and the compare result.
  always_comb begin
    exp_data = DATA_W'(pattern(PAT_W'(seed), PAT_W'(cmp_idx)));
    mismatch = rdv && (rdata != exp_data);
  end

  // Compare index, saturating error counter and first-error capture.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cmp_idx        <= '0;
      err_seen       <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (clr) begin
      cmp_idx        <= '0;
      err_seen       <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (rdv) begin
      cmp_idx <= cmp_idx + CNT_W'(1);
      if (mismatch) begin
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        if (!err_seen) begin
          err_seen       <= 1'b1;
          first_err_addr <= base + ADDR_W'(cmp_idx);
        end
      end
    end
  end

endmodule

// File: rtl/mem_check_ctrl.sv
// Memory checker control engine: drives an Avalon-MM master through a
// contiguous address range with a seed-derived pattern, pipelines reads up to
// MAX_OUTST outstanding, and reports busy/done/error status.
//
// state | meaning
// IDLE  | waiting for start
// WRITE | presenting write for the current index
// READ  | presenting read for the current index (throttled when full)
// DRAIN | all reads issued, waiting for outstanding data to return
// DONE  | one-cycle done pulse, back to IDLE next
module mem_check_ctrl
  import mem_check_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_OUTST = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  cmd_cnt_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic [ADDR_W-1:0] amm_address_o,
  output logic              amm_write_o,
  output logic [DATA_W-1:0] amm_writedata_o,
  output logic              amm_read_o,
  input  logic              amm_waitrequest_i,
  input  logic [DATA_W-1:0] amm_readdata_i,
  input  logic              amm_readdatavalid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              cfg_err_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  state_t            state, state_nxt;
  mode_t             mode;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] seed;
  logic [CNT_W-1:0]  idx;
  logic [OUT_W-1:0]  outst;
  logic              cfg_err;

  logic start_ok;
  logic rdv_ok;
  logic rd_full;
  logic wr_acc;
  logic rd_acc;
  logic last_idx;

  // Handshake qualifiers; a return with nothing outstanding is stray and dropped.
  always_comb begin
    start_ok = start_i && (state == IDLE);
    rdv_ok   = amm_readdatavalid_i && (outst != '0);
    rd_full  = (outst == OUT_W'(MAX_OUTST)) && !rdv_ok;
    last_idx = (idx == cnt - CNT_W'(1));
  end

  // Next-state and Avalon request outputs.
  always_comb begin
    state_nxt       = state;
    amm_write_o     = 1'b0;
    amm_read_o      = 1'b0;
    amm_address_o   = '0;
    amm_writedata_o = '0;
    wr_acc          = 1'b0;
    rd_acc          = 1'b0;
    busy_o          = (state != IDLE);
    done_o          = (state == DONE);

    case (state)
      IDLE: begin
        if (start_i) begin
          if (mode_i == 2'b11) begin
            state_nxt = DONE;
          end else if (cmd_cnt_i == '0) begin
            state_nxt = DONE;
          end else if (mode_i == 2'b01) begin
            state_nxt = READ;
          end else begin
            state_nxt = WRITE;
          end
        end
      end

      WRITE: begin
        amm_write_o     = 1'b1;
        amm_address_o   = base + ADDR_W'(idx);
        amm_writedata_o = DATA_W'(pattern(PAT_W'(seed), PAT_W'(idx)));
        wr_acc          = !amm_waitrequest_i;
        if (wr_acc) begin
          if (mode == WR) begin
            state_nxt = READ;
          end else if (last_idx) begin
            state_nxt = DONE;
          end
        end
      end

      READ: begin
        amm_read_o    = !rd_full;
        amm_address_o = base + ADDR_W'(idx);
        rd_acc        = amm_read_o && !amm_waitrequest_i;
        if (rd_acc) begin
          if (last_idx) begin
            state_nxt = DRAIN;
          end else if (mode == WR) begin
            state_nxt = WRITE;
          end
        end
      end

      DRAIN: begin
        if (outst == '0) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset aborts any run on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Run configuration, latched only on an accepted start.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mode    <= WO;
      base    <= '0;
      cnt     <= '0;
      seed    <= '0;
      cfg_err <= 1'b0;
    end else if (start_ok) begin
      mode    <= mode_t'(mode_i);
      base    <= base_addr_i;
      cnt     <= cmd_cnt_i;
      seed    <= seed_i;
      cfg_err <= (mode_i == 2'b11);
    end
  end

  // Command index: writes in mode WR do not advance, the paired read does.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      idx <= '0;
    end else if (start_ok) begin
      idx <= '0;
    end else if ((wr_acc && (mode == WO)) || rd_acc) begin
      idx <= idx + CNT_W'(1);
    end
  end

  // Outstanding-read tracker; simultaneous issue and return cancel out.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      outst <= '0;
    end else begin
      case ({rd_acc, rdv_ok})
        2'b10:   outst <= outst + OUT_W'(1);
        2'b01:   outst <= outst - OUT_W'(1);
        default: outst <= outst;
      endcase
    end
  end

  assign cfg_err_o = cfg_err;

  mem_check_rd_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_rd_cmp (
    .clk            (clk_i),
    .rst_b          (rst_i),
    .clr            (start_ok),
    .rdv            (rdv_ok),
    .rdata          (amm_readdata_i),
    .base           (base),
    .seed           (seed),
    .err_cnt        (err_cnt_o),
    .first_err_addr (first_err_addr_o)
  );

endmodule

// File: tb/tb_mem_check_ctrl.sv
// Directed bench for mem_check_ctrl with an Avalon slave model (memory,
// configurable read latency, optional random stalls and data corruption).
module tb_mem_check_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  mode_i;
  logic [31:0] base_addr_i;
  logic [15:0] cmd_cnt_i;
  logic [31:0] seed_i;
  logic [31:0] amm_address_o;
  logic        amm_write_o;
  logic [31:0] amm_writedata_o;
  logic        amm_read_o;
  logic        waitreq;
  logic [31:0] rdata;
  logic        rdv;
  logic        busy_o;
  logic        done_o;
  logic        cfg_err_o;
  logic [15:0] err_cnt_o;
  logic [31:0] first_err_addr_o;

  always #5 clk = ~clk;

  mem_check_ctrl #(
    .ADDR_W(32), .DATA_W(32), .CNT_W(16), .MAX_OUTST(4)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .start_i             (start_i),
    .mode_i              (mode_i),
    .base_addr_i         (base_addr_i),
    .cmd_cnt_i           (cmd_cnt_i),
    .seed_i              (seed_i),
    .amm_address_o       (amm_address_o),
    .amm_write_o         (amm_write_o),
    .amm_writedata_o     (amm_writedata_o),
    .amm_read_o          (amm_read_o),
    .amm_waitrequest_i   (waitreq),
    .amm_readdata_i      (rdata),
    .amm_readdatavalid_i (rdv),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .cfg_err_o           (cfg_err_o),
    .err_cnt_o           (err_cnt_o),
    .first_err_addr_o    (first_err_addr_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_ent_t;

  rd_ent_t     rq[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] rd_addr[$];
  bit          kinds[$];

  int  cyc = 0;
  int  lat = 3;
  bit  rand_wait = 0;
  bit  hold_rd = 0;
  bit  corrupt_en = 0;
  logic [31:0] corrupt_addr = '0;
  int  outst_tb = 0;
  int  max_outst = 0;
  int  n_rdv = 0;
  int  last_rdv = 0;
  int  stab_err = 0;
  int  both_err = 0;
  int  rd_throttle = 0;
  int  done_at = 0;

  bit          prev_stall = 0;
  logic        prev_rd, prev_wr;
  logic [31:0] prev_addr, prev_data;

  // Slave model: returns on the falling edge, then decides what the next
  // rising edge accepts once the DUT's request has settled.
  initial begin
    rdv = 1'b0;
    rdata = '0;
    waitreq = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      rdv = 1'b0;
      rdata = '0;
      if (!hold_rd && rq.size() > 0 && rq[0].due <= cyc) begin
        rdv = 1'b1;
        rdata = rq[0].data;
        void'(rq.pop_front());
        outst_tb--;
        last_rdv = cyc;
        n_rdv++;
      end
      waitreq = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (!rst_i) begin
        rq.delete();
        outst_tb = 0;
        prev_stall = 0;
      end else begin
        if (amm_write_o && amm_read_o) both_err++;
        if (prev_stall && (amm_read_o !== prev_rd || amm_write_o !== prev_wr ||
            amm_address_o !== prev_addr || (amm_write_o && amm_writedata_o !== prev_data)))
          stab_err++;
        if (busy_o && !amm_read_o && !amm_write_o && outst_tb == 4) rd_throttle++;
        prev_stall = (amm_read_o || amm_write_o) && waitreq;
        prev_rd = amm_read_o;
        prev_wr = amm_write_o;
        prev_addr = amm_address_o;
        prev_data = amm_writedata_o;
        if (!waitreq && amm_write_o) begin
          mem[amm_address_o] = amm_writedata_o;
          wr_addr.push_back(amm_address_o);
          wr_data.push_back(amm_writedata_o);
          kinds.push_back(1'b0);
        end
        if (!waitreq && amm_read_o) begin
          rd_ent_t e;
          e.due = cyc + lat;
          e.data = mem.exists(amm_address_o) ? mem[amm_address_o] : 32'hDEAD_0000;
          if (corrupt_en && amm_address_o == corrupt_addr) e.data = e.data ^ 32'h1;
          rq.push_back(e);
          rd_addr.push_back(amm_address_o);
          kinds.push_back(1'b1);
          outst_tb++;
          if (outst_tb > max_outst) max_outst = outst_tb;
        end
      end
    end
  end

  task automatic preload(input logic [31:0] b, input int c, input logic [31:0] s);
    for (int i = 0; i < c; i++) mem[b + 32'(i)] = s ^ 32'(i);
  endtask

  // Called on a falling edge; leaves start high across exactly one rising edge.
  task automatic begin_run(input logic [1:0] m, input logic [31:0] b,
                           input logic [15:0] c, input logic [31:0] s);
    wr_addr.delete();
    wr_data.delete();
    rd_addr.delete();
    kinds.delete();
    max_outst = 0;
    n_rdv = 0;
    stab_err = 0;
    both_err = 0;
    rd_throttle = 0;
    mode_i = m;
    base_addr_i = b;
    cmd_cnt_i = c;
    seed_i = s;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int waited);
    int k = 0;
    while (done_o !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    waited = k;
    done_at = cyc;
    chk({tag, "_done"}, 32'(done_o), 1);
    chk({tag, "_busy_in_done"}, 32'(busy_o), 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done_o), 0);
    chk({tag, "_busy_after"}, 32'(busy_o), 0);
  endtask

  int w;
  int alt_err;
  int seq_err;

  initial begin
    rst_i = 1'b0;
    start_i = 1'b0;
    mode_i = '0;
    base_addr_i = '0;
    cmd_cnt_i = '0;
    seed_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_cfg_err", 32'(cfg_err_o), 0);
    chk("rst_err_cnt", 32'(err_cnt_o), 0);
    chk("rst_first_err", first_err_addr_o, 0);
    chk("rst_read", 32'(amm_read_o), 0);
    chk("rst_write", 32'(amm_write_o), 0);
    chk("rst_addr", amm_address_o, 0);
    chk("rst_wdata", amm_writedata_o, 0);
    rst_i = 1'b1;
    @(negedge clk);

    // Write-only run.
    lat = 3;
    begin_run(2'b00, 32'h100, 16'd4, 32'hA5A5A5A5);
    wait_done("wo", 200, w);
    chk("wo_nwr", 32'(wr_addr.size()), 4);
    chk("wo_nrd", 32'(rd_addr.size()), 0);
    chk("wo_a0", wr_addr[0], 32'h100);
    chk("wo_a3", wr_addr[3], 32'h103);
    chk("wo_d0", wr_data[0], 32'hA5A5A5A5);
    chk("wo_d1", wr_data[1], 32'hA5A5A5A4);
    chk("wo_d2", wr_data[2], 32'hA5A5A5A7);
    chk("wo_d3", wr_data[3], 32'hA5A5A5A6);
    chk("wo_err", 32'(err_cnt_o), 0);

    // Read-only, long latency: outstanding limit must throttle.
    lat = 10;
    preload(32'h1000, 16, 32'hDEADBEEF);
    begin_run(2'b01, 32'h1000, 16'd16, 32'hDEADBEEF);
    wait_done("ro", 800, w);
    lat = 3;
    chk("ro_nrd", 32'(rd_addr.size()), 16);
    chk("ro_nrdv", 32'(n_rdv), 16);
    chk("ro_max_outst", 32'(max_outst), 4);
    chk("ro_throttled", 32'(rd_throttle > 0), 1);
    chk("ro_done_after_rdv", 32'(done_at > last_rdv), 1);
    chk("ro_outst_end", 32'(outst_tb), 0);
    chk("ro_a15", rd_addr[15], 32'h100F);
    chk("ro_err", 32'(err_cnt_o), 0);

    // Write-then-read with corrupted read at index 3.
    corrupt_en = 1;
    corrupt_addr = 32'h203;
    begin_run(2'b10, 32'h200, 16'd8, 32'h12345678);
    wait_done("wr", 400, w);
    corrupt_en = 0;
    alt_err = 0;
    foreach (kinds[i]) if (kinds[i] != (i % 2 == 1)) alt_err++;
    chk("wr_nwr", 32'(wr_addr.size()), 8);
    chk("wr_nrd", 32'(rd_addr.size()), 8);
    chk("wr_alternate", 32'(alt_err), 0);
    chk("wr_d3", wr_data[3], 32'h1234567B);
    chk("wr_err_cnt", 32'(err_cnt_o), 1);
    chk("wr_first_err", first_err_addr_o, 32'h203);

    // Reserved mode: rejected, immediate done, counters cleared.
    begin_run(2'b11, 32'h500, 16'd5, 32'h0);
    wait_done("rsvd", 20, w);
    chk("rsvd_latency", 32'(w), 0);
    chk("rsvd_cfg_err", 32'(cfg_err_o), 1);
    chk("rsvd_err_clr", 32'(err_cnt_o), 0);
    chk("rsvd_first_clr", first_err_addr_o, 0);
    chk("rsvd_traffic", 32'(wr_addr.size() + rd_addr.size()), 0);

    // Zero count: no traffic, cfg_err cleared by the new start.
    begin_run(2'b00, 32'h600, 16'd0, 32'h0);
    wait_done("zero", 20, w);
    chk("zero_latency", 32'(w), 0);
    chk("zero_cfg_err", 32'(cfg_err_o), 0);
    chk("zero_traffic", 32'(wr_addr.size() + rd_addr.size()), 0);

    // Start while busy is ignored.
    preload(32'h300, 4, 32'h0F0F0F0F);
    begin_run(2'b01, 32'h300, 16'd4, 32'h0F0F0F0F);
    mode_i = 2'b11;
    base_addr_i = 32'h900;
    cmd_cnt_i = 16'd9;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("busy_start", 200, w);
    chk("bs_cfg_err", 32'(cfg_err_o), 0);
    chk("bs_nrd", 32'(rd_addr.size()), 4);
    chk("bs_a3", rd_addr[3], 32'h303);
    chk("bs_err", 32'(err_cnt_o), 0);

    // Random stalls, address wrap at the top of the space.
    rand_wait = 1;
    begin_run(2'b10, 32'hFFFFFFFA, 16'd12, 32'hCAFEF00D);
    wait_done("rnd", 2000, w);
    rand_wait = 0;
    seq_err = 0;
    foreach (wr_addr[i]) begin
      if (wr_addr[i] != 32'hFFFFFFFA + 32'(i)) seq_err++;
      if (wr_data[i] != (32'hCAFEF00D ^ 32'(i))) seq_err++;
    end
    foreach (rd_addr[i]) if (rd_addr[i] != 32'hFFFFFFFA + 32'(i)) seq_err++;
    alt_err = 0;
    foreach (kinds[i]) if (kinds[i] != (i % 2 == 1)) alt_err++;
    chk("rnd_stable", 32'(stab_err), 0);
    chk("rnd_one_req", 32'(both_err), 0);
    chk("rnd_nwr", 32'(wr_addr.size()), 12);
    chk("rnd_nrd", 32'(rd_addr.size()), 12);
    chk("rnd_sequence", 32'(seq_err), 0);
    chk("rnd_alternate", 32'(alt_err), 0);
    chk("rnd_wrap", wr_addr[6], 32'h0);
    chk("rnd_err", 32'(err_cnt_o), 0);

    // Reset mid-READ with three reads outstanding; returns are withheld.
    hold_rd = 1;
    begin_run(2'b01, 32'h700, 16'd8, 32'h0);
    w = 0;
    while (outst_tb < 3 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("abort_outst", 32'(outst_tb), 3);
    rst_i = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_read", 32'(amm_read_o), 0);
    chk("abort_addr", amm_address_o, 0);
    chk("abort_done", 32'(done_o), 0);
    chk("abort_err", 32'(err_cnt_o), 0);
    rst_i = 1'b1;
    hold_rd = 0;
    @(negedge clk);
    preload(32'h40, 4, 32'h5);
    begin_run(2'b01, 32'h40, 16'd4, 32'h5);
    wait_done("post", 200, w);
    chk("post_nrd", 32'(rd_addr.size()), 4);
    chk("post_nrdv", 32'(n_rdv), 4);
    chk("post_err", 32'(err_cnt_o), 0);
    chk("post_first", first_err_addr_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
